// File: rtl/decoder_seq.sv
// decoder_seq: registered one-hot / thermometer decoder with a sweep mode.
// A single output register gives a one-stage, full-throughput pipeline in
// PASS; a sweep request walks a one-hot bit through all OUT_W positions,
// optionally separated by DWELL idle cycles, before returning to PASS.
module decoder_seq #(
   parameter  int IN_W  = 2,
   parameter  int DWELL = 0,
   localparam int OUT_W = 2**IN_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_code,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out,
   output logic             busy
);

   typedef enum logic {
      ST_PASS  = 1'b0,
      ST_SWEEP = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      MODE_ONEHOT = 2'b00,
      MODE_THERMO = 2'b01,
      MODE_SWEEP  = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_t;

   // Word count of the final sweep word and the dwell reload value.
   localparam logic [IN_W:0] LAST_WORD = (IN_W+1)'(OUT_W - 1);
   localparam logic [7:0]    DWELL_CYC = 8'(DWELL);
   localparam bit            NO_DWELL  = (DWELL == 0);

   state_t            r_state, w_state_nxt;
   logic [OUT_W-1:0]  r_out, w_out_nxt;
   logic              r_out_valid, w_out_valid_nxt;
   logic [IN_W-1:0]   r_idx, w_idx_nxt;          // current sweep position
   logic [IN_W:0]     r_word_cnt, w_word_cnt_nxt; // sweep words presented - 1
   logic [7:0]        r_dwell_cnt, w_dwell_cnt_nxt;

   logic              w_accept;
   logic              w_out_hs;
   logic [IN_W-1:0]   w_idx_inc;
   logic [OUT_W-1:0]  w_onehot;
   logic [OUT_W-1:0]  w_thermo;
   logic [OUT_W-1:0]  w_sweep_cur;
   logic [OUT_W-1:0]  w_sweep_inc;

   // Only PASS can take a request, and only when the output slot frees up.
   assign in_ready  = rst_n && (r_state == ST_PASS) && (!r_out_valid || out_ready);
   assign w_accept  = in_valid && in_ready;
   assign w_out_hs  = r_out_valid && out_ready;
   assign w_idx_inc = r_idx + IN_W'(1);

   assign out       = r_out;
   assign out_valid = r_out_valid;
   assign busy      = (r_state == ST_SWEEP);

   // Decode the incoming code and the sweep positions into output words.
   always_comb begin
      w_onehot              = '0;
      w_onehot[in_code]     = 1'b1;
      w_sweep_cur           = '0;
      w_sweep_cur[r_idx]    = 1'b1;
      w_sweep_inc           = '0;
      w_sweep_inc[w_idx_inc] = 1'b1;
      for (int i = 0; i < OUT_W; i++) begin
         w_thermo[i] = (i <= int'(in_code));
      end
   end

   // Next-state and datapath update for both FSM states.
   always_comb begin
      // NOTE: every target gets a default first, so no path can infer a latch.
      w_state_nxt     = r_state;
      w_out_nxt       = r_out;
      w_out_valid_nxt = r_out_valid;
      w_idx_nxt       = r_idx;
      w_word_cnt_nxt  = r_word_cnt;
      w_dwell_cnt_nxt = r_dwell_cnt;

      case (r_state)
         ST_PASS: begin
            if (w_accept) begin
               w_out_valid_nxt = 1'b1;
               case (mode)
                  MODE_THERMO: w_out_nxt = w_thermo;
                  MODE_SWEEP: begin
                     w_out_nxt       = w_onehot;
                     w_idx_nxt       = in_code;
                     w_word_cnt_nxt  = '0;
                     w_dwell_cnt_nxt = '0;
                     w_state_nxt     = ST_SWEEP;
                  end
                  default:     w_out_nxt = w_onehot; // one-hot and reserved
               endcase
            end else if (w_out_hs) begin
               w_out_valid_nxt = 1'b0;
            end
         end

         ST_SWEEP: begin
            if (w_out_hs) begin
               if (r_word_cnt == LAST_WORD) begin
                  w_state_nxt     = ST_PASS;
                  w_out_valid_nxt = 1'b0;
                  w_idx_nxt       = '0;
                  w_word_cnt_nxt  = '0;
                  w_dwell_cnt_nxt = '0;
               end else begin
                  w_idx_nxt      = w_idx_inc;
                  w_word_cnt_nxt = r_word_cnt + (IN_W+1)'(1);
                  if (NO_DWELL) begin
                     w_out_nxt       = w_sweep_inc;
                     w_out_valid_nxt = 1'b1;
                  end else begin
                     w_out_valid_nxt = 1'b0;
                     w_dwell_cnt_nxt = DWELL_CYC;
                  end
               end
            end else if (!r_out_valid) begin
               // Dwell gap: r_idx already points at the next word.
               if (r_dwell_cnt <= 8'd1) begin
                  w_out_nxt       = w_sweep_cur;
                  w_out_valid_nxt = 1'b1;
                  w_dwell_cnt_nxt = '0;
               end else begin
                  w_dwell_cnt_nxt = r_dwell_cnt - 8'd1;
               end
            end
         end

         default: w_state_nxt = ST_PASS;
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: the output word is reset too, so out reads 0 straight after reset.
      if (!rst_n) begin
         r_state     <= ST_PASS;
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_idx       <= '0;
         r_word_cnt  <= '0;
         r_dwell_cnt <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         r_state     <= w_state_nxt;
         r_out       <= w_out_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_idx       <= w_idx_nxt;
         r_word_cnt  <= w_word_cnt_nxt;
         r_dwell_cnt <= w_dwell_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq: scoreboard bench. Two instances (DWELL = 0 and DWELL = 2)
// share one stimulus stream; each accepted request expands into expected
// words (with required presentation cycle) that a negedge monitor pops on
// every output handshake.
module tb_decoder_seq;

   localparam int IN_W  = 2;
   localparam int OUT_W = 4;

   typedef struct {
      logic [OUT_W-1:0] word;
      bit               sweep;      // belongs to a sweep (affects busy)
      bit               after_prev; // due DWELL+1 cycles after previous handshake
      int               due;        // absolute presentation cycle otherwise
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic [IN_W-1:0]  in_code = '0;
   logic [1:0]       mode = 2'b00;
   logic             out_ready = 1'b1;

   logic             in_ready0, out_valid0, busy0;
   logic [OUT_W-1:0] out0;
   logic             in_ready1, out_valid1, busy1;
   logic [OUT_W-1:0] out1;

   exp_t             sb [2][$];
   int               sweep_left [2] = '{0, 0};
   int               dwell_of   [2] = '{0, 2};
   bit               prev_valid [2] = '{0, 0};
   bit               prev_hs    [2] = '{0, 0};
   logic [OUT_W-1:0] prev_out   [2];
   int               start_cyc  [2] = '{0, 0};
   int               last_hs    [2] = '{0, 0};
   bit               prev_rst_low = 1'b0;
   int               cyc = 0;
   int               total = 0;
   int               bad = 0;

   decoder_seq #(.IN_W(IN_W), .DWELL(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .in_code(in_code), .mode(mode), .out_valid(out_valid0),
      .out_ready(out_ready), .out(out0), .busy(busy0)
   );

   decoder_seq #(.IN_W(IN_W), .DWELL(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .in_code(in_code), .mode(mode), .out_valid(out_valid1),
      .out_ready(out_ready), .out(out1), .busy(busy1)
   );

   always #5 clk = ~clk;

   // Cycle counter used to time-stamp acceptances and presentations.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int d,
                        input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d cyc=%0d: got %0h expected %0h", name, d, cyc, act, exp);
      end
   endtask

   // Reference model: expand one accepted request into expected words.
   task automatic model_accept(input int d, input logic [IN_W-1:0] code,
                               input logic [1:0] md);
      exp_t e;
      int   c;
      c = int'(code);
      e.sweep = 1'b0;
      e.after_prev = 1'b0;
      e.due = cyc + 1;
      case (md)
         2'b01: begin
            e.word = OUT_W'((1 << (c + 1)) - 1);
            sb[d].push_back(e);
         end
         2'b10: begin
            for (int k = 0; k < OUT_W; k++) begin
               e.word = OUT_W'(1 << ((c + k) % OUT_W));
               e.sweep = 1'b1;
               e.after_prev = (k != 0);
               sb[d].push_back(e);
            end
            sweep_left[d] += OUT_W;
         end
         default: begin
            e.word = OUT_W'(1 << c);
            sb[d].push_back(e);
         end
      endcase
   endtask

   // Apply one cycle of stimulus and record what each instance accepts.
   task automatic drive(input logic v, input logic [IN_W-1:0] code,
                        input logic [1:0] md, input logic ordy, input logic rst);
      in_valid  = v;
      in_code   = code;
      mode      = md;
      out_ready = ordy;
      rst_n     = rst;
      #6;
      for (int d = 0; d < 2; d++) begin
         logic ir;
         ir = (d == 0) ? in_ready0 : in_ready1;
         if (!rst_n) begin
            sb[d].delete();
            sweep_left[d] = 0;
         end else if (in_valid && ir) begin
            model_accept(d, in_code, mode);
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Idle with out_ready high until both scoreboards are empty (bounded).
   task automatic wait_quiet();
      int n;
      n = 0;
      while ((sweep_left[0] != 0 || sweep_left[1] != 0 ||
              sb[0].size() != 0 || sb[1].size() != 0) && n < 200) begin
         drive(1'b0, '0, 2'b00, 1'b1, 1'b1);
         n++;
      end
      if (sb[0].size() != 0 || sb[1].size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: pending dut0=%0d dut1=%0d expected 0",
                  sb[0].size(), sb[1].size());
      end
   endtask

   // Monitor step for one instance, evaluated mid-cycle.
   task automatic mon_step(input int d, input logic ov, input logic [OUT_W-1:0] ow,
                           input logic bz, input logic ir);
      exp_t e;
      int   due;
      bit   hs, new_word;
      if (prev_rst_low) check("reset_state", d, {ov, bz, ow}, '0);
      if (!rst_n) begin
         check("ready_in_reset", d, ir, 0);
         prev_valid[d] = 1'b0;
         prev_hs[d] = 1'b0;
         return;
      end
      check("busy", d, bz, sweep_left[d] > 0);
      check("in_ready", d, ir, (sweep_left[d] == 0) && (!ov || out_ready));
      new_word = ov && (!prev_valid[d] || prev_hs[d]);
      if (new_word) start_cyc[d] = cyc;
      else if (ov) check("hold", d, ow, prev_out[d]);
      hs = ov && out_ready;
      if (hs) begin
         if (sb[d].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word dut%0d cyc=%0d: got %0h expected none", d, cyc, ow);
         end else begin
            e = sb[d].pop_front();
            due = e.after_prev ? (last_hs[d] + 1 + dwell_of[d]) : e.due;
            check("word", d, ow, e.word);
            check("present_cycle", d, start_cyc[d], due);
            if (e.sweep) sweep_left[d]--;
         end
         last_hs[d] = cyc;
      end
      prev_valid[d] = ov;
      prev_hs[d] = hs;
      prev_out[d] = ow;
   endtask

   // Monitor: sample both instances on the falling edge.
   always @(negedge clk) begin
      mon_step(0, out_valid0, out0, busy0, in_ready0);
      mon_step(1, out_valid1, out1, busy1, in_ready1);
      prev_rst_low = !rst_n;
   end

   // Stimulus: directed scenarios, then a randomized phase.
   initial begin
      @(posedge clk);
      #1;
      repeat (3) drive(1'($urandom), IN_W'($urandom), 2'($urandom), 1'b1, 1'b0);

      // One-hot 0..3 back-to-back, starting on the first edge out of reset.
      for (int c = 0; c < OUT_W; c++) drive(1'b1, IN_W'(c), 2'b00, 1'b1, 1'b1);
      // Thermometer 2, 0, 3.
      drive(1'b1, 2'd2, 2'b01, 1'b1, 1'b1);
      drive(1'b1, 2'd0, 2'b01, 1'b1, 1'b1);
      drive(1'b1, 2'd3, 2'b01, 1'b1, 1'b1);
      wait_quiet();

      // Stall one-hot 1 for five cycles while other requests are offered.
      drive(1'b1, 2'd1, 2'b00, 1'b1, 1'b1);
      repeat (5) drive(1'b1, IN_W'($urandom), 2'($urandom), 1'b0, 1'b1);
      drive(1'b0, '0, 2'b00, 1'b1, 1'b1);
      wait_quiet();

      // Sweep from base 2.
      drive(1'b1, 2'd2, 2'b10, 1'b1, 1'b1);
      repeat (4) drive(1'b0, '0, 2'b00, 1'b1, 1'b1);
      wait_quiet();

      // Sweep from base 0 with requests offered throughout.
      drive(1'b1, 2'd0, 2'b10, 1'b1, 1'b1);
      repeat (12) drive(1'b1, IN_W'($urandom), 2'b00, 1'b1, 1'b1);
      wait_quiet();

      // Reset after the second sweep word, then one-hot 3.
      drive(1'b1, 2'd1, 2'b10, 1'b1, 1'b1);
      drive(1'b0, '0, 2'b00, 1'b1, 1'b1);
      drive(1'b0, '0, 2'b00, 1'b1, 1'b1);
      drive(1'b0, '0, 2'b00, 1'b1, 1'b0);
      drive(1'b1, 2'd3, 2'b00, 1'b1, 1'b1);
      wait_quiet();

      // Randomized traffic with back-pressure and rare resets.
      repeat (400) begin
         drive(1'($urandom), IN_W'($urandom), 2'($urandom),
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) != 0));
      end
      wait_quiet();
      repeat (2) drive(1'b0, '0, 2'b00, 1'b1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decoder_seq.md
DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 Parameter IN_W, default 2: code width; legal range 1..6.
REQ-002 Parameter DWELL, default 0: idle gap in cycles between sweep words; legal range 0..255.
REQ-003 Derived width OUT_W = 2**IN_W: output width; not overridable.
REQ-004 Port clk, input, 1: single clock; all state is updated on its rising edge.
REQ-005 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 Port in_valid, input, 1: an input request is present.
REQ-007 Port in_ready, output, 1: the block accepts a request this cycle.
REQ-008 Port in_code, input, IN_W: code to decode.
REQ-009 Port mode, input, 2: 00 one-hot, 01 thermometer, 10 sweep, 11 reserved and treated as 00.
REQ-010 Port out_valid, output, 1: out holds a valid word.
REQ-011 Port out_ready, input, 1: downstream accepts the word.
REQ-012 Port out, output, OUT_W: decoded word.
REQ-013 Port busy, output, 1: high while a sweep is in progress.

Function
REQ-014 The block shall accept an input when in_valid && in_ready, sampling in_code and mode on that edge.
REQ-015 The block shall produce an output handshake when out_valid && out_ready.
REQ-016 The FSM shall have exactly two states: PASS and SWEEP.
REQ-017 In PASS, in_ready shall equal !out_valid || out_ready, giving a single-stage pipeline with full throughput.
REQ-018 In SWEEP, in_ready shall be 0.
REQ-019 One-hot mode shall register out = 1 << in_code, with out_valid = 1 on the cycle after acceptance (latency 1).
REQ-020 Thermometer mode shall register out bits [in_code:0] = 1 and all higher bits 0, with latency 1.
REQ-021 While out_valid && !out_ready, out and out_valid shall hold stable, and no input shall be accepted.
REQ-022 In PASS, an output handshake with no simultaneous acceptance shall clear out_valid on the next cycle.
REQ-023 In PASS, a simultaneous output handshake and acceptance shall load the new word with no bubble.
REQ-024 Accepting mode=10 in PASS shall enter SWEEP, set busy = 1, and latch base = in_code.
REQ-025 A sweep shall emit exactly OUT_W words; word k (k = 0..OUT_W-1) is 1 << ((base + k) mod OUT_W).
REQ-026 Sweep indices shall wrap modulo OUT_W.
REQ-027 Word 0 of a sweep shall appear with latency 1 after acceptance.
REQ-028 After each sweep-word handshake except the last, out_valid shall stay 0 for exactly DWELL cycles before the next word is presented.
REQ-029 With DWELL = 0, sweep words shall be presented back-to-back on consecutive handshakes.
REQ-030 The dwell counter shall not start until the word's handshake occurs; out_ready stalls extend the sweep.
REQ-031 On the handshake of word OUT_W-1, the FSM shall return to PASS, drive busy = 0 and out_valid = 0 on the next cycle, and assert in_ready in that same next cycle.
REQ-032 With IN_W = 1, a sweep shall emit 2 words, and thermometer code 1 shall be 2'b11.
REQ-033 The sweep word counter shall be IN_W+1 bits wide and the dwell counter 8 bits wide; neither shall overflow within legal parameter ranges.
REQ-034 mode and in_code changes while not accepted shall have no effect.

Reset
REQ-035 While rst_n = 0 at a clk edge, the FSM shall go to PASS, and out_valid = 0, out = 0, busy = 0, and all counters = 0 on the next cycle.
REQ-036 in_ready shall be 0 while rst_n = 0.
REQ-037 Reset mid-sweep shall abort the sweep immediately; no further sweep words are emitted.
REQ-038 The first acceptance shall be possible on the first edge with rst_n = 1.

Verification (IN_W = 2)
REQ-039 Reset, then one-hot codes 0,1,2,3 back-to-back with out_ready = 1 -> out = 0001, 0010, 0100, 1000 on consecutive cycles, each one cycle after acceptance, with no bubbles.
REQ-040 Thermometer code 2 -> out = 0111; code 0 -> out = 0001; code 3 -> out = 1111.
REQ-041 One-hot code 1 with out_ready held 0 for 5 cycles -> out = 0010 stable, out_valid = 1, in_ready = 0 throughout; one word delivered on release.
REQ-042 Sweep with base 2, DWELL = 0, out_ready = 1 -> out = 0100, 1000, 0001, 0010 on 4 consecutive cycles; busy = 1 for those cycles; in_ready returns to 1 the cycle after the last word.
REQ-043 Sweep with base 0, DWELL = 2 -> out_valid pattern 1,0,0,1,0,0,1,0,0,1; requests offered with in_valid = 1 during the sweep are not accepted.
REQ-044 rst_n = 0 asserted after the second sweep word -> next cycle out_valid = 0, busy = 0, out = 0; a subsequent one-hot code 3 yields out = 1000.
